sat_accumulator: RTL and testbench
==================================

SAT_ACCUMULATOR -- requirements
Module: sat_accumulator

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, two's complement; WIDTH >= 3 SHALL be supported.
REQ-002 Parameter ACC_LEN, default 4: samples per accumulation group; ACC_LEN >= 1 SHALL be supported.
REQ-003 Parameter SYM, default 1: 1 = symmetric range [-(2^(WIDTH-1)-1), +(2^(WIDTH-1)-1)]; 0 = full range [-2^(WIDTH-1), +(2^(WIDTH-1)-1)].
REQ-004 clk_80  in  1  single clock; all state SHALL change on the rising edge.
REQ-005 rst_80  in  1  reset, asynchronous, active-high.
REQ-006 in_valid_80  in  1  input sample valid.
REQ-007 in_ready_80  out  1  block accepts the sample this cycle.
REQ-008 in_data_80  in  WIDTH  signed input sample.
REQ-009 clear_80  in  1  synchronous discard of the partial group.
REQ-010 sat_en_80  in  1  1 = saturate, 0 = wrap; sampled with each accepted sample.
REQ-011 out_valid_80  out  1  group result valid.
REQ-012 out_ready_80  in  1  downstream accepts the result.
REQ-013 out_data_80  out  WIDTH  signed group result.
REQ-014 out_sat_80  out  1  at least one overflow or clamp occurred in this group.

Function
REQ-015 A sample SHALL be accepted iff in_valid_80 && in_ready_80 at a rising edge.
REQ-016 in_ready_80 SHALL equal !clear_80 && !(out_valid_80 && !out_ready_80), with no combinational path from in_valid_80.
REQ-017 The state SHALL consist of:
- accumulator acc (WIDTH bits)
- counter cnt (0..ACC_LEN-1)
- sticky flag sflag
- output register holding out_data_80, out_sat_80 and out_valid_80
REQ-018 On each accepted sample, the SHALL compute the sum s = acc + x in WIDTH+1 bits, where x = in_data_80. When sat_en_80=1, SYM=1 and in_data_80 = -2^(WIDTH-1), x SHALL be -(2^(WIDTH-1)-1) and sflag SHALL be set.
REQ-019 Saturate mode: if s > MAX, the result SHALL be MAX; if s < MIN, the result SHALL be MIN, where MIN/MAX follow SYM. Saturation SHALL apply at every step, not only at the end of the group. Any clip SHALL set sflag.
REQ-020 Wrap mode: the result SHALL be s truncated to WIDTH bits. Signed overflow SHALL set sflag. In wrap mode the result is not clamped to the SYM range.
REQ-021 If cnt < ACC_LEN-1, an accepted sample SHALL update acc and increment cnt.
REQ-022 If cnt = ACC_LEN-1, an accepted sample SHALL:
- load the step result into out_data_80;
- load sflag OR this step's flag into out_sat_80;
- set out_valid_80;
- reset acc to 0, cnt to 0 and sflag to 0.
REQ-023 Latency: the result SHALL be visible on the outputs in the cycle after the edge that accepts the group's last sample.
REQ-024 The first sample of each group SHALL add to 0; ACC_LEN=1 SHALL give a pass-through with 1-cycle latency, saturating or clamping the sample.
REQ-025 out_valid_80 SHALL clear at an edge where out_valid_80 && out_ready_80, unless a new group completes at the same edge, in which case the new result SHALL load and out_valid_80 SHALL stay high.
REQ-026 While out_valid_80 && !out_ready_80, out_data_80 and out_sat_80 SHALL hold stable.
REQ-027 clear_80=1 SHALL zero acc, cnt and sflag at the edge and take priority over an input sample in the same cycle; the sample is not accepted. clear_80 SHALL NOT affect a pending output.
REQ-028 Changing sat_en_80 mid-group SHALL affect only subsequent steps.

Reset
REQ-029 rst_80 high SHALL immediately force acc=0, cnt=0, sflag=0, out_valid_80=0, out_data_80=0 and out_sat_80=0, independent of clk_80.
REQ-030 After rst_80 deasserts, the first accepted sample SHALL start a new group; any partial group or pending result SHALL be lost.
REQ-031 in_ready_80 SHALL be 1 while in reset, given clear_80=0.

Verification (WIDTH=8, ACC_LEN=4, SYM=1)
REQ-032 Samples 10, 20, 30, 40 with sat_en=1 -> out_data=100 (0x64), out_sat=0, one cycle after the 4th accept.
REQ-033 Samples 100, 100, -50, 10 with sat_en=1 -> 200 clips to 127, then 77, then 87 -> out_data=87, out_sat=1.
REQ-034 Samples 100, 100, 0, 0 with sat_en=0 -> out_data=-56 (0xC8), out_sat=1.
REQ-035 Samples -128 x4 with sat_en=1 -> inputs clamp to -127 and sums pin at -127 -> out_data=-127 (0x81), out_sat=1.
REQ-036 Group A completes with out_ready=0 for 3 cycles -> in_ready=0, out_data holds A. Group B's 4th sample is offered while out_ready=1 -> B is accepted, and out_valid stays high with B loaded.
REQ-037 Two samples 5, 5 accepted, then rst_80 pulses mid-cycle -> all outputs 0 at once. Samples 1, 2, 3, 4 then give out_data=10. The same sequence with clear_80 instead of reset also gives 10.

Source files
------------

// File: rtl/sat_accumulator.sv
// Groups ACC_LEN signed samples into one result, with per-step saturation or wrap
// and a sticky overflow flag; the result sits in a valid/ready output register.
module sat_accumulator #(
  parameter int WIDTH   = 8,
  parameter int ACC_LEN = 4,
  parameter int SYM     = 1
) (
  input  logic             clk_80,
  input  logic             rst_80,
  input  logic             in_valid_80,
  output logic             in_ready_80,
  input  logic [WIDTH-1:0] in_data_80,
  input  logic             clear_80,
  input  logic             sat_en_80,
  output logic             out_valid_80,
  input  logic             out_ready_80,
  output logic [WIDTH-1:0] out_data_80,
  output logic             out_sat_80
);

  localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(ACC_LEN - 1);

  // Limits are held in WIDTH+1 bits so they compare directly against the raw sum.
  localparam logic signed [WIDTH:0] C_MAX      = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0] C_MIN_FULL = {2'b11, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH:0] C_MIN_SYM  = {2'b11, {(WIDTH-2){1'b0}}, 1'b1};
  localparam logic signed [WIDTH:0] C_MIN      = (SYM != 0) ? C_MIN_SYM : C_MIN_FULL;
  localparam logic [WIDTH-1:0]      C_IN_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]        r_acc;
  logic [CW-1:0]           r_cnt;
  logic                    r_sflag;
  logic                    r_out_valid;
  logic [WIDTH-1:0]        r_out_data;
  logic                    r_out_sat;

  logic                    w_accept;
  logic [WIDTH-1:0]        w_x;
  logic                    w_in_clamp;
  logic signed [WIDTH:0]   w_sum;
  logic [WIDTH-1:0]        w_result;
  logic                    w_step_flag;

  assign in_ready_80  = !clear_80 && !(r_out_valid && !out_ready_80);
  assign w_accept     = in_valid_80 && in_ready_80;
  assign out_valid_80 = r_out_valid;
  assign out_data_80  = r_out_data;
  assign out_sat_80   = r_out_sat;

  // One accumulation step: input clamp, widened add, then saturate or wrap.
  always_comb begin
    w_x         = in_data_80;
    w_in_clamp  = 1'b0;
    if (sat_en_80 && (SYM != 0) && (in_data_80 == C_IN_MOST_NEG)) begin
      w_x        = C_MIN_SYM[WIDTH-1:0];
      w_in_clamp = 1'b1;
    end else begin
      w_x        = in_data_80;
    end
    w_sum       = $signed({r_acc[WIDTH-1], r_acc}) + $signed({w_x[WIDTH-1], w_x});
    w_result    = w_sum[WIDTH-1:0];
    w_step_flag = w_in_clamp;
    if (sat_en_80) begin
      if (w_sum > C_MAX) begin
        w_result    = C_MAX[WIDTH-1:0];
        w_step_flag = 1'b1;
      end else if (w_sum < C_MIN) begin
        w_result    = C_MIN[WIDTH-1:0];
        w_step_flag = 1'b1;
      end else begin
        w_result    = w_sum[WIDTH-1:0];
      end
    end else begin
      w_result    = w_sum[WIDTH-1:0];
      w_step_flag = (w_sum[WIDTH] != w_sum[WIDTH-1]);
    end
  end

  // Accumulator, group counter, sticky flag and output register.
  always_ff @(posedge clk_80 or posedge rst_80) begin
    if (rst_80) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sflag     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      if (clear_80) begin
        r_acc   <= '0;
        r_cnt   <= '0;
        r_sflag <= 1'b0;
      end else if (w_accept && (r_cnt != C_LAST)) begin
        r_acc   <= w_result;
        r_cnt   <= r_cnt + CW'(1);
        r_sflag <= r_sflag | w_step_flag;
      end else if (w_accept) begin
        r_acc   <= '0;
        r_cnt   <= '0;
        r_sflag <= 1'b0;
      end else begin
        r_acc   <= r_acc;
      end

      // A completing group wins over a drain at the same edge.
      if (w_accept && (r_cnt == C_LAST)) begin
        r_out_data  <= w_result;
        r_out_sat   <= r_sflag | w_step_flag;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready_80) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
    end
  end

endmodule

// File: tb/tb_sat_accumulator.sv
// Scoreboard bench: directed groups push hand-computed results; monitors compare on handshake.
module tb_sat_accumulator;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0, in_valid1 = 1'b0;
  logic       in_ready, in_ready1;
  logic [7:0] in_data = 8'd0;
  logic       clear = 1'b0, clear1 = 1'b0;
  logic       sat_en = 1'b0;
  logic       out_valid, out_valid1;
  logic       out_ready = 1'b1, out_ready1 = 1'b1;
  logic [7:0] out_data, out_data1;
  logic       out_sat, out_sat1;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  sat_accumulator #(.WIDTH(8), .ACC_LEN(4), .SYM(1)) dut (
    .clk_80(clk), .rst_80(rst), .in_valid_80(in_valid), .in_ready_80(in_ready),
    .in_data_80(in_data), .clear_80(clear), .sat_en_80(sat_en),
    .out_valid_80(out_valid), .out_ready_80(out_ready),
    .out_data_80(out_data), .out_sat_80(out_sat));

  sat_accumulator #(.WIDTH(8), .ACC_LEN(1), .SYM(1)) dut1 (
    .clk_80(clk), .rst_80(rst), .in_valid_80(in_valid1), .in_ready_80(in_ready1),
    .in_data_80(in_data), .clear_80(clear1), .sat_en_80(sat_en),
    .out_valid_80(out_valid1), .out_ready_80(out_ready1),
    .out_data_80(out_data1), .out_sat_80(out_sat1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one sample to the ACC_LEN=4 instance; returns at posedge+1 after acceptance.
  task automatic send(input logic [7:0] x, input logic s);
    bit ok;
    ok = 1'b0;
    in_data  = x;
    sat_en   = s;
    in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for sample %0d", $signed(x));
    end
  endtask

  task automatic group4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d, input logic s);
    send(a, s);
    send(b, s);
    send(c, s);
    send(d, s);
  endtask

  // Monitor for the ACC_LEN=4 instance.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_tests++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL dut_unexpected: got data=%0d sat=%0b, expected no result",
                 $signed(out_data), out_sat);
      end else begin
        e0 = q0.pop_front();
        if (out_data !== e0.d || out_sat !== e0.s) begin
          n_fail++;
          $display("FAIL dut_result: got data=%0d sat=%0b, expected data=%0d sat=%0b",
                   $signed(out_data), out_sat, $signed(e0.d), e0.s);
        end
      end
    end
  end

  // Monitor for the pass-through ACC_LEN=1 instance.
  always @(negedge clk) begin
    if (!rst && out_valid1 && out_ready1) begin
      n_tests++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL dut1_unexpected: got data=%0d sat=%0b, expected no result",
                 $signed(out_data1), out_sat1);
      end else begin
        e1 = q1.pop_front();
        if (out_data1 !== e1.d || out_sat1 !== e1.s) begin
          n_fail++;
          $display("FAIL dut1_result: got data=%0d sat=%0b, expected data=%0d sat=%0b",
                   $signed(out_data1), out_sat1, $signed(e1.d), e1.s);
        end
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {24'd0, out_data},  32'd0);
    chk("rst_out_sat",   {31'd0, out_sat},   32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 10+20+30+40 = 100, one cycle after the 4th accept
    q0.push_back('{8'h64, 1'b0});
    group4(8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_data",  {24'd0, out_data},  32'h64);

    // 100+100 clips to 127, -50 -> 77, +10 -> 87
    q0.push_back('{8'd87, 1'b1});
    group4(8'd100, 8'd100, 8'hCE, 8'd10, 1'b1);

    // wrap: 200 -> -56 with overflow
    q0.push_back('{8'hC8, 1'b1});
    group4(8'd100, 8'd100, 8'd0, 8'd0, 1'b0);

    // -128 clamps to -127 and sums pin at -127
    q0.push_back('{8'h81, 1'b1});
    group4(8'h80, 8'h80, 8'h80, 8'h80, 1'b1);

    // wrap mode reaches -128 without overflow and is not clamped
    q0.push_back('{8'h80, 1'b0});
    group4(8'h9C, 8'hE4, 8'd0, 8'd0, 1'b0);

    // sat_en changes mid-group: 120, wrap 140 -> -116 (flag), +10 sat -> -106, +0
    q0.push_back('{8'h96, 1'b1});
    send(8'd120, 1'b1);
    send(8'd20,  1'b0);
    send(8'd10,  1'b1);
    send(8'd0,   1'b0);

    // backpressure: group A pending for 3 cycles, then group B streams in
    idle(2);
    out_ready = 1'b0;
    q0.push_back('{8'd4, 1'b0});
    group4(8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_in_ready",  {31'd0, in_ready},  32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_out_data",  {24'd0, out_data},  32'd4);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    q0.push_back('{8'h7F, 1'b1});
    group4(8'd100, 8'd100, 8'd0, 8'd0, 1'b1);
    chk("b_valid", {31'd0, out_valid}, 32'd1);
    chk("b_data",  {24'd0, out_data},  32'h7F);

    // mid-cycle reset drops a partial group and clears held outputs
    idle(2);
    send(8'd5, 1'b1);
    send(8'd5, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_data",  {24'd0, out_data},  32'd0);
    chk("mid_rst_out_sat",   {31'd0, out_sat},   32'd0);
    chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    q0.push_back('{8'd10, 1'b0});
    group4(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);

    // clear drops a partial group and wins over a concurrent sample
    idle(2);
    send(8'd5, 1'b1);
    send(8'd5, 1'b1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd7;
    @(negedge clk);
    chk("clear_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    q0.push_back('{8'd10, 1'b0});
    group4(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    idle(2);

    // ACC_LEN=1: back-to-back pass-through, result loads while previous drains
    in_valid1 = 1'b1;
    in_data = 8'd50;  sat_en = 1'b1; q1.push_back('{8'd50, 1'b0});
    @(negedge clk);
    chk("p1_in_ready", {31'd0, in_ready1}, 32'd1);
    @(posedge clk); #1;
    in_data = 8'h80;  sat_en = 1'b1; q1.push_back('{8'h81, 1'b1});
    @(posedge clk); #1;
    chk("p1_stay_valid", {31'd0, out_valid1}, 32'd1);
    in_data = 8'h80;  sat_en = 1'b0; q1.push_back('{8'h80, 1'b0});
    @(posedge clk); #1;
    in_data = 8'd127; sat_en = 1'b1; q1.push_back('{8'h7F, 1'b0});
    @(posedge clk); #1;
    in_valid1 = 1'b0;

    for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) begin
      @(posedge clk);
    end
    idle(2);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
